// File: rtl/ascon_controller_if.sv
// rtl/ascon_controller_if.sv - block handshake and datapath control bundle for ascon_controller
// Optional feature macro: ASCON_CTRL_ABORT_EN (adds i_abort)
interface ascon_controller_if #(
  parameter int BLK_W = 4
);
  logic             i_start;
  logic [BLK_W-1:0] i_ad_blocks;
  logic [BLK_W-1:0] i_pt_blocks;
  logic             i_block_valid;
`ifdef ASCON_CTRL_ABORT_EN
  logic             i_abort;
`endif
  logic             o_block_req;
  logic             o_block_is_pt;
  logic             o_sys_enable;
  logic             o_mux_select;
  logic             o_enable_xor_key_begin;
  logic             o_enable_xor_data_begin;
  logic             o_enable_xor_key_end;
  logic             o_enable_xor_lsb_end;
  logic             o_enable_state_reg;
  logic             o_enable_cipher_reg;
  logic             o_enable_tag_reg;
  logic [3:0]       o_round;
  logic             o_cipher_valid;
  logic             o_done;
  logic             o_busy;

  modport master (
    output i_start, i_ad_blocks, i_pt_blocks, i_block_valid,
`ifdef ASCON_CTRL_ABORT_EN
    output i_abort,
`endif
    input  o_block_req, o_block_is_pt, o_sys_enable, o_mux_select,
    input  o_enable_xor_key_begin, o_enable_xor_data_begin,
    input  o_enable_xor_key_end, o_enable_xor_lsb_end,
    input  o_enable_state_reg, o_enable_cipher_reg, o_enable_tag_reg,
    input  o_round, o_cipher_valid, o_done, o_busy
  );

  modport slave (
    input  i_start, i_ad_blocks, i_pt_blocks, i_block_valid,
`ifdef ASCON_CTRL_ABORT_EN
    input  i_abort,
`endif
    output o_block_req, o_block_is_pt, o_sys_enable, o_mux_select,
    output o_enable_xor_key_begin, o_enable_xor_data_begin,
    output o_enable_xor_key_end, o_enable_xor_lsb_end,
    output o_enable_state_reg, o_enable_cipher_reg, o_enable_tag_reg,
    output o_round, o_cipher_valid, o_done, o_busy
  );
endinterface

// File: rtl/ascon_controller.sv
// rtl/ascon_controller.sv - ASCON-128 round/phase sequencer (init p12, AD p6, PT p6, final p12)
// Optional feature macro: ASCON_CTRL_ABORT_EN (i_abort soft-clears the datapath and returns to IDLE)
module ascon_controller #(
  parameter int BLK_W = 4
) (
  input logic               clock,
  input logic               reset,
  ascon_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_AD_WAIT, S_AD_RND, S_PT_WAIT, S_PT_RND, S_FIN_RND, S_DONE
  } state_t;

  localparam logic [3:0]       R_FIRST_P6 = 4'd6;
  localparam logic [3:0]       R_LAST     = 4'd11;
  localparam logic [BLK_W-1:0] CNT_ONE    = {{(BLK_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [BLK_W-1:0] ad_cnt_q, ad_cnt_d;
  logic [BLK_W-1:0] pt_cnt_q, pt_cnt_d;
  logic             cv_q;
  logic             sys_en_q;
  logic             abort_hit;

  logic       req, is_pt, mux, xkb, xdb, xke, xle, sen, cen, ten, done;
  logic [3:0] round;

  // pt_cnt_q counts remaining PT blocks including the one being requested
  wire last_pt = (pt_cnt_q == CNT_ONE);
  wire ad_left = (ad_cnt_q != '0);

`ifdef ASCON_CTRL_ABORT_EN
  assign abort_hit = bus.i_abort && (state_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // state, round index, block counters, cipher strobe and sys enable registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rnd_q    <= '0;
      ad_cnt_q <= '0;
      pt_cnt_q <= '0;
      cv_q     <= 1'b0;
      sys_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      ad_cnt_q <= ad_cnt_d;
      pt_cnt_q <= pt_cnt_d;
      cv_q     <= cen;
      sys_en_q <= !abort_hit;
    end
  end

  // next-state and datapath controls; WAIT states are Mealy on i_block_valid
  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    ad_cnt_d = ad_cnt_q;
    pt_cnt_d = pt_cnt_q;
    req      = 1'b0;
    is_pt    = 1'b0;
    mux      = 1'b0;
    xkb      = 1'b0;
    xdb      = 1'b0;
    xke      = 1'b0;
    xle      = 1'b0;
    sen      = 1'b0;
    cen      = 1'b0;
    ten      = 1'b0;
    done     = 1'b0;
    round    = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d  = S_INIT;
          rnd_d    = 4'd0;
          ad_cnt_d = bus.i_ad_blocks;
          pt_cnt_d = (bus.i_pt_blocks == '0) ? CNT_ONE : bus.i_pt_blocks;
        end
      end

      S_INIT: begin
        sen   = 1'b1;
        mux   = (rnd_q != 4'd0);
        round = rnd_q;
        if (rnd_q == R_LAST) begin
          xke     = 1'b1;
          xle     = !ad_left;
          rnd_d   = 4'd0;
          state_d = ad_left ? S_AD_WAIT : S_PT_WAIT;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end

      S_AD_WAIT: begin
        req   = 1'b1;
        mux   = 1'b1;
        xdb   = 1'b1;
        round = R_FIRST_P6;
        if (bus.i_block_valid) begin
          sen      = 1'b1;
          ad_cnt_d = ad_cnt_q - CNT_ONE;
          rnd_d    = R_FIRST_P6 + 4'd1;
          state_d  = S_AD_RND;
        end
      end

      S_AD_RND: begin
        sen   = 1'b1;
        mux   = 1'b1;
        round = rnd_q;
        if (rnd_q == R_LAST) begin
          // counter already decremented at handshake: zero here means last AD block
          xle     = !ad_left;
          rnd_d   = 4'd0;
          state_d = ad_left ? S_AD_WAIT : S_PT_WAIT;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end

      S_PT_WAIT: begin
        req   = 1'b1;
        is_pt = 1'b1;
        mux   = 1'b1;
        xdb   = 1'b1;
        round = last_pt ? 4'd0 : R_FIRST_P6;
        if (bus.i_block_valid) begin
          sen      = 1'b1;
          cen      = 1'b1;
          pt_cnt_d = pt_cnt_q - CNT_ONE;
          if (last_pt) begin
            xkb     = 1'b1;
            rnd_d   = 4'd1;
            state_d = S_FIN_RND;
          end else begin
            rnd_d   = R_FIRST_P6 + 4'd1;
            state_d = S_PT_RND;
          end
        end
      end

      S_PT_RND: begin
        sen   = 1'b1;
        mux   = 1'b1;
        round = rnd_q;
        if (rnd_q == R_LAST) begin
          rnd_d   = 4'd0;
          state_d = S_PT_WAIT;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end

      S_FIN_RND: begin
        sen   = 1'b1;
        mux   = 1'b1;
        round = rnd_q;
        if (rnd_q == R_LAST) begin
          xke     = 1'b1;
          ten     = 1'b1;
          rnd_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // abort beats any handshake in the same cycle: nothing is written, no pulses follow
    if (abort_hit) begin
      state_d  = S_IDLE;
      rnd_d    = 4'd0;
      ad_cnt_d = '0;
      pt_cnt_d = '0;
      req      = 1'b0;
      is_pt    = 1'b0;
      mux      = 1'b0;
      xkb      = 1'b0;
      xdb      = 1'b0;
      xke      = 1'b0;
      xle      = 1'b0;
      sen      = 1'b0;
      cen      = 1'b0;
      ten      = 1'b0;
      done     = 1'b0;
      round    = 4'd0;
    end
  end

  assign bus.o_block_req             = req;
  assign bus.o_block_is_pt           = is_pt;
  assign bus.o_sys_enable            = sys_en_q;
  assign bus.o_mux_select            = mux;
  assign bus.o_enable_xor_key_begin  = xkb;
  assign bus.o_enable_xor_data_begin = xdb;
  assign bus.o_enable_xor_key_end    = xke;
  assign bus.o_enable_xor_lsb_end    = xle;
  assign bus.o_enable_state_reg      = sen;
  assign bus.o_enable_cipher_reg     = cen;
  assign bus.o_enable_tag_reg        = ten;
  assign bus.o_round                 = round;
  assign bus.o_cipher_valid          = cv_q;
  assign bus.o_done                  = done;
  assign bus.o_busy                  = (state_q != S_IDLE);

endmodule

// File: tb/tb_ascon_controller.sv
// tb/tb_ascon_controller.sv - self-checking bench for ascon_controller against a phase-level trace model
module tb_ascon_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ascon_controller_if #(.BLK_W(4)) bus ();
  ascon_controller #(.BLK_W(4)) dut (.clock(clk), .reset(rst), .bus(bus.slave));

  int errors = 0;
  int checks = 0;

  // expected-vector bit layout
  localparam int B_BUSY = 17, B_SYS = 14, B_CEN = 7, B_CV = 1;

  typedef struct packed {
    logic        start;
    logic        valid;
    logic [17:0] exp;
  } ent_t;

  ent_t tr[$];

  function automatic logic [17:0] obs();
    return {bus.o_busy, bus.o_block_req, bus.o_block_is_pt, bus.o_sys_enable,
            bus.o_mux_select, bus.o_enable_xor_key_begin, bus.o_enable_xor_data_begin,
            bus.o_enable_xor_key_end, bus.o_enable_xor_lsb_end, bus.o_enable_state_reg,
            bus.o_enable_cipher_reg, bus.o_enable_tag_reg, bus.o_round,
            bus.o_cipher_valid, bus.o_done};
  endfunction

  task automatic chk(input string tag, input int idx, input logic [17:0] o, input logic [17:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, o, e);
    end
  endtask

  // one expected cycle; sys_enable is 1 outside reset, cipher_valid filled in afterwards
  task automatic add(input logic busy, req, ispt, mux, xkb, xdb, xke, xle, sen, cen, ten,
                     input int rnd, input logic done, input logic valid, input logic start);
    ent_t e;
    logic [3:0] r;
    r = rnd[3:0];
    e.start = start;
    e.valid = valid;
    e.exp   = {busy, req, ispt, 1'b1, mux, xkb, xdb, xke, xle, sen, cen, ten, r, 1'b0, done};
    tr.push_back(e);
  endtask

  function automatic logic noise_bit(input logic noise, input logic dflt);
    return noise ? 1'($urandom_range(0, 1)) : dflt;
  endfunction

  function automatic int pick_stall(input int stall);
    return (stall >= 0) ? stall : int'($urandom_range(0, 3));
  endfunction

  // Builds the expected cycle trace from the phase rules: p12 init, p6 per AD block,
  // p6 per non-final PT block, then p12 finalization entered with the last PT block.
  task automatic build(input int ad, input int pt, input int stall, input logic noise);
    int npt;
    int s;
    ent_t e;
    tr.delete();
    npt = (pt == 0) ? 1 : pt;
    add(0,0,0,0,0,0,0,0,0,0,0, 0, 0, noise_bit(noise, 1'b1), 1'b1);
    for (int r = 0; r < 12; r++)
      add(1,0,0, r != 0, 0,0, r == 11, (r == 11) && (ad == 0), 1,0,0, r, 0,
          noise_bit(noise, 1'b1), noise_bit(noise, 1'b0));
    for (int b = 0; b < ad; b++) begin
      s = pick_stall(stall);
      for (int k = 0; k < s; k++)
        add(1,1,0,1,0,1,0,0,0,0,0, 6, 0, 1'b0, noise_bit(noise, 1'b0));
      add(1,1,0,1,0,1,0,0,1,0,0, 6, 0, 1'b1, noise_bit(noise, 1'b0));
      for (int r = 7; r < 12; r++)
        add(1,0,0,1,0,0,0, (r == 11) && (b == ad - 1), 1,0,0, r, 0,
            noise_bit(noise, 1'b1), noise_bit(noise, 1'b0));
    end
    for (int p = 0; p < npt - 1; p++) begin
      s = pick_stall(stall);
      for (int k = 0; k < s; k++)
        add(1,1,1,1,0,1,0,0,0,0,0, 6, 0, 1'b0, noise_bit(noise, 1'b0));
      add(1,1,1,1,0,1,0,0,1,1,0, 6, 0, 1'b1, noise_bit(noise, 1'b0));
      for (int r = 7; r < 12; r++)
        add(1,0,0,1,0,0,0,0,1,0,0, r, 0, noise_bit(noise, 1'b1), noise_bit(noise, 1'b0));
    end
    s = pick_stall(stall);
    for (int k = 0; k < s; k++)
      add(1,1,1,1,0,1,0,0,0,0,0, 0, 0, 1'b0, noise_bit(noise, 1'b0));
    add(1,1,1,1,1,1,0,0,1,1,0, 0, 0, 1'b1, noise_bit(noise, 1'b0));
    for (int r = 1; r < 12; r++)
      add(1,0,0,1,0,0, r == 11, 0,1,0, r == 11, r, 0,
          noise_bit(noise, 1'b1), noise_bit(noise, 1'b0));
    add(1,0,0,0,0,0,0,0,0,0,0, 0, 1, noise_bit(noise, 1'b1), noise_bit(noise, 1'b0));
    add(0,0,0,0,0,0,0,0,0,0,0, 0, 0, 1'b0, 1'b0);
    // cipher_valid follows any cipher-register enable by one cycle
    for (int i = 1; i < tr.size(); i++) begin
      e = tr[i];
      e.exp[B_CV] = tr[i-1].exp[B_CEN];
      tr[i] = e;
    end
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    bus.i_start       = 1'b0;
    bus.i_block_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
  endtask

  // rst_at/abort_at: trace index at which to inject reset or abort (-1 = none)
  task automatic run(input string tag, input int ad, input int pt, input int stall,
                     input logic noise, input int rst_at, input int abort_at);
    logic [17:0] m;
    build(ad, pt, stall, noise);
    bus.i_ad_blocks = 4'(ad);
    bus.i_pt_blocks = 4'(pt);
    for (int i = 0; i < tr.size(); i++) begin
      @(negedge clk);
      bus.i_start       = tr[i].start;
      bus.i_block_valid = tr[i].valid;
`ifdef ASCON_CTRL_ABORT_EN
      if (i == abort_at) begin
        bus.i_abort = 1'b1;
        #1;
        m = '0;
        m[B_BUSY] = 1'b1;
        m[B_SYS]  = 1'b1;
        m[B_CV]   = tr[i].exp[B_CV];
        chk({tag, "_abort"}, i, obs(), m);
        @(negedge clk);
        bus.i_abort = 1'b0;
        bus.i_start = 1'b0;
        #1;
        chk({tag, "_softclr"}, i, obs(), 18'd0);
        @(negedge clk);
        #1;
        m = '0;
        m[B_SYS] = 1'b1;
        chk({tag, "_idle"}, i, obs(), m);
        return;
      end
`endif
      #1;
      chk(tag, i, obs(), tr[i].exp);
      if (i == rst_at) begin
        #2;
        rst = 1'b1;
        #1;
        chk({tag, "_rst"}, i, obs(), 18'd0);
        reset_cycle();
        return;
      end
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.i_start       = 1'b0;
    bus.i_ad_blocks   = '0;
    bus.i_pt_blocks   = '0;
    bus.i_block_valid = 1'b0;
`ifdef ASCON_CTRL_ABORT_EN
    bus.i_abort       = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_state", 0, obs(), 18'd0);
    reset_cycle();

    run("ad1pt1", 1, 1, 0, 1'b0, -1, -1);
    run("ad0pt2", 0, 2, -1, 1'b1, -1, -1);
    run("ad2pt1_stall3", 2, 1, 3, 1'b1, -1, -1);
    run("rst_init5", 1, 1, 0, 1'b0, 6, -1);
    run("after_rst", 1, 2, -1, 1'b1, -1, -1);
    for (int n = 0; n < 6; n++)
      run("rand", int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), -1, 1'b1, -1, -1);
    run("ad15pt0", 15, 0, -1, 1'b1, -1, -1);
    run("ad0pt15", 0, 15, -1, 1'b1, -1, -1);
`ifdef ASCON_CTRL_ABORT_EN
    // FIN rnd4 sits 7 entries before FIN rnd11, which is 2 before the trailing IDLE entry
    build(1, 1, 0, 1'b0);
    run("abort_fin4", 1, 1, 0, 1'b0, -1, tr.size() - 10);
    run("after_abort", 1, 1, 0, 1'b0, -1, -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
